// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_pkg
// Brief    : Shared types and constants for the system-bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package bus_pkg;

  // Bus widths
  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;

  // Transfer size encodings carried on the HB field
  localparam logic [1:0] HB_BYTE = 2'b00;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_WORD = 2'b10;

  // Arbiter state: free, owned, or one-cycle turnaround between owners
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } bus_state_e;

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_if
// Brief    : Master-side and slave-side bus signals around the arbiter.
//            Names are from the arbiter's point of view.
// Revision : 1.0 - initial release
// ============================================================================
interface bus_arbiter_if #(
  parameter int N_MASTERS = 2
) ();
  import bus_pkg::*;

  // Master side
  logic [N_MASTERS-1:0]        i_REQ;
  logic [N_MASTERS-1:0]        o_GNT;
  logic [BUS_AW*N_MASTERS-1:0] i_M_ADDR;
  logic [BUS_DW*N_MASTERS-1:0] i_M_WDATA;
  logic [N_MASTERS-1:0]        i_M_WE;
  logic [N_MASTERS-1:0]        i_M_RE;
  logic [2*N_MASTERS-1:0]      i_M_HB;
  logic [BUS_DW-1:0]           o_M_RDATA;
  logic [N_MASTERS-1:0]        o_M_ACK;

  // Slave side
  logic [BUS_AW-1:0]           o_S_ADDR;
  logic [BUS_DW-1:0]           o_S_WDATA;
  logic                        o_S_WE;
  logic                        o_S_RE;
  logic [1:0]                  o_S_HB;
  logic [BUS_DW-1:0]           i_S_RDATA;
  logic                        i_S_ACK;

  // The arbiter itself
  modport arb (
    input  i_REQ, i_M_ADDR, i_M_WDATA, i_M_WE, i_M_RE, i_M_HB,
    input  i_S_RDATA, i_S_ACK,
    output o_GNT, o_M_RDATA, o_M_ACK,
    output o_S_ADDR, o_S_WDATA, o_S_WE, o_S_RE, o_S_HB
  );

  // The set of bus masters (fetch, load/store, debug/DMA)
  modport master (
    output i_REQ, i_M_ADDR, i_M_WDATA, i_M_WE, i_M_RE, i_M_HB,
    input  o_GNT, o_M_RDATA, o_M_ACK
  );

  // The memory/peripheral interconnect
  modport slave (
    input  o_S_ADDR, o_S_WDATA, o_S_WE, o_S_RE, o_S_HB,
    output i_S_RDATA, i_S_ACK
  );

endinterface
`default_nettype wire

// File: rtl/bus_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Brief    : Combinational round-robin search. Starting at i_ptr and wrapping,
//            returns the first index whose request is set and not masked.
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  wire logic [N-1:0]  i_req,
  input  wire logic [N-1:0]  i_mask,
  input  wire logic [IW-1:0] i_ptr,
  output logic               o_valid,
  output logic [IW-1:0]      o_idx
);

  logic [N-1:0] w_elig;
  logic [IW:0]  w_pos;

  assign w_elig = i_req & ~i_mask;

  // Walk ptr, ptr+1, ... (mod N); the first eligible index wins
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_pos   = '0;
    for (int i = 0; i < N; i++) begin
      w_pos = {1'b0, i_ptr} + (IW+1)'(i);
      if (w_pos >= (IW+1)'(N)) begin
        w_pos = w_pos - (IW+1)'(N);
      end
      if (!o_valid && w_elig[w_pos[IW-1:0]]) begin
        o_valid = 1'b1;
        o_idx   = w_pos[IW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Brief    : Round-robin system-bus arbiter. Locks ownership until the owner
//            drops its request, muxes the owner onto the slave side, and
//            force-releases an owner that goes TIMEOUT cycles without an ack.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int TIMEOUT   = 255
) (
  input  wire logic   i_CLK,
  input  wire logic   i_RSTn,
  bus_arbiter_if.arb  bus,
  output logic        o_BUSY,
  output logic        o_TIMEOUT
);

  localparam int IW = $clog2(N_MASTERS);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] c_TO_MAX  = CW'(TIMEOUT);
  // Counter value at which one more ack-less cycle reaches TIMEOUT
  localparam logic [CW-1:0] c_TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  bus_state_e           r_state;
  logic [N_MASTERS-1:0] r_gnt;
  logic [IW-1:0]        r_owner;
  logic [IW-1:0]        r_ptr;
  logic [N_MASTERS-1:0] r_mask;
  logic [CW-1:0]        r_cnt;
  logic                 r_busy;
  logic                 r_timeout;

  logic                 w_pick_vld;
  logic [IW-1:0]        w_pick_idx;
  logic [IW-1:0]        w_next_ptr;
  logic [N_MASTERS-1:0] w_own_oh;
  logic                 w_owned;
  logic                 w_wd_fire;

  rr_picker #(
    .N  (N_MASTERS),
    .IW (IW)
  ) u_picker (
    .i_req   (bus.i_REQ),
    .i_mask  (r_mask),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_vld),
    .o_idx   (w_pick_idx)
  );

  assign w_owned    = (r_state == OWN);
  assign w_own_oh   = {{(N_MASTERS-1){1'b0}}, 1'b1} << r_owner;
  assign w_next_ptr = (r_owner == IW'(N_MASTERS - 1)) ? '0 : r_owner + 1'b1;
  // The owner is cut off on the edge where its ack-less count would reach TIMEOUT
  assign w_wd_fire  = (TIMEOUT != 0) && !bus.i_S_ACK && (r_cnt == c_TO_LAST);

  // Arbitration FSM with registered grant, busy and timeout outputs
  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_mask    <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      // A timed-out master is forgiven once it withdraws its request
      r_mask    <= r_mask & bus.i_REQ;
      case (r_state)
        IDLE: begin
          if (w_pick_vld) begin
            r_owner <= w_pick_idx;
            r_gnt   <= {{(N_MASTERS-1){1'b0}}, 1'b1} << w_pick_idx;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= OWN;
          end
        end
        OWN: begin
          if (!bus.i_REQ[r_owner]) begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= w_next_ptr;
            r_state <= TURN;
          end else if (w_wd_fire) begin
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_ptr     <= w_next_ptr;
            r_timeout <= 1'b1;
            r_mask    <= (r_mask & bus.i_REQ) | w_own_oh;
            r_cnt     <= c_TO_MAX;
            r_state   <= TURN;
          end else if (bus.i_S_ACK) begin
            r_cnt <= '0;
          end else if (r_cnt != c_TO_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        TURN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Slave-side mux driven from the registered owner; all zero when unowned
  always_comb begin
    bus.o_S_ADDR  = '0;
    bus.o_S_WDATA = '0;
    bus.o_S_WE    = 1'b0;
    bus.o_S_RE    = 1'b0;
    bus.o_S_HB    = 2'b00;
    bus.o_M_ACK   = '0;
    if (w_owned) begin
      for (int k = 0; k < N_MASTERS; k++) begin
        if (r_owner == IW'(k)) begin
          bus.o_S_ADDR  = bus.i_M_ADDR[k*BUS_AW +: BUS_AW];
          bus.o_S_WDATA = bus.i_M_WDATA[k*BUS_DW +: BUS_DW];
          bus.o_S_WE    = bus.i_M_WE[k];
          bus.o_S_RE    = bus.i_M_RE[k];
          bus.o_S_HB    = bus.i_M_HB[2*k +: 2];
        end
      end
      bus.o_M_ACK = bus.i_S_ACK ? w_own_oh : '0;
    end
  end

  assign bus.o_GNT     = r_gnt;
  assign bus.o_M_RDATA = bus.i_S_RDATA;
  assign o_BUSY        = r_busy;
  assign o_TIMEOUT     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Brief    : Self-checking bench for bus_arbiter (2 masters, TIMEOUT = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  localparam int NM = 2;

  logic clk;
  logic rstn;
  logic busy;
  logic tmo;

  int n_checks = 0;
  int n_fail   = 0;

  bus_arbiter_if #(.N_MASTERS(NM)) bif ();

  bus_arbiter #(
    .N_MASTERS (NM),
    .TIMEOUT   (4)
  ) dut (
    .i_CLK     (clk),
    .i_RSTn    (rstn),
    .bus       (bif),
    .o_BUSY    (busy),
    .o_TIMEOUT (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rstn;
    logic [1:0]  req;
    logic        ack;
    logic [1:0]  gnt;
    logic        busy;
    logic        tmo;
    logic [31:0] saddr;
    logic [1:0]  mack;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [1:0] q, logic a, logic [1:0] g,
                              logic b, logic t, logic [31:0] sa, logic [1:0] ma);
    vec_t v;
    v.rstn = r; v.req = q; v.ack = a; v.gnt = g;
    v.busy = b; v.tmo = t; v.saddr = sa; v.mack = ma;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Slave-side fields implied by which master (identified by address) owns the bus
  task automatic chk_slave(input string tag, input logic [31:0] saddr);
    logic [31:0] e_wd;
    logic        e_we, e_re;
    logic [1:0]  e_hb;
    e_wd = 32'h0; e_we = 1'b0; e_re = 1'b0; e_hb = 2'b00;
    if (saddr == 32'h0000_1000) begin
      e_wd = 32'hAAAA_0000; e_we = 1'b1; e_hb = 2'b10;
    end else if (saddr == 32'h0000_2000) begin
      e_wd = 32'hBBBB_1111; e_re = 1'b1; e_hb = 2'b01;
    end
    chk({tag, ".s_addr"},  bif.o_S_ADDR, saddr);
    chk({tag, ".s_wdata"}, bif.o_S_WDATA, e_wd);
    chk({tag, ".s_we"},    {31'h0, bif.o_S_WE}, {31'h0, e_we});
    chk({tag, ".s_re"},    {31'h0, bif.o_S_RE}, {31'h0, e_re});
    chk({tag, ".s_hb"},    {30'h0, bif.o_S_HB}, {30'h0, e_hb});
  endtask

  task automatic cyc(input logic r, input logic [1:0] q, input logic a);
    rstn        = r;
    bif.i_REQ   = q;
    bif.i_S_ACK = a;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_gt(input string tag, input logic [1:0] g, input logic t);
    chk({tag, ".gnt"}, {30'h0, bif.o_GNT}, {30'h0, g});
    chk({tag, ".tmo"}, {31'h0, tmo}, {31'h0, t});
  endtask

  // Global time limit so the run can never hang
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    // Master 0: word write to 0x1000; master 1: half read from 0x2000
    bif.i_M_ADDR  = {32'h0000_2000, 32'h0000_1000};
    bif.i_M_WDATA = {32'hBBBB_1111, 32'hAAAA_0000};
    bif.i_M_WE    = 2'b01;
    bif.i_M_RE    = 2'b10;
    bif.i_M_HB    = {2'b01, 2'b10};
    bif.i_S_RDATA = 32'h0;
    bif.i_S_ACK   = 1'b0;
    bif.i_REQ     = 2'b00;
    rstn          = 1'b0;

    //                rstn  req   ack  gnt   busy to  saddr         mack
    // reset, single master grant / ack / release / TURN
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0,    2'b00));
    vecs.push_back(mk(1'b1, 2'b01, 1'b0, 2'b01, 1'b1, 1'b0, 32'h1000, 2'b00));
    vecs.push_back(mk(1'b1, 2'b01, 1'b1, 2'b01, 1'b1, 1'b0, 32'h1000, 2'b01));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0,    2'b00));
    vecs.push_back(mk(1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0,    2'b00));
    // simultaneous requests after reset, handoff two cycles later
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0,    2'b00));
    vecs.push_back(mk(1'b1, 2'b11, 1'b0, 2'b01, 1'b1, 1'b0, 32'h1000, 2'b00));
    vecs.push_back(mk(1'b1, 2'b11, 1'b1, 2'b01, 1'b1, 1'b0, 32'h1000, 2'b01));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0,    2'b00));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0,    2'b00));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 2'b10, 1'b1, 1'b0, 32'h2000, 2'b00));
    vecs.push_back(mk(1'b1, 2'b10, 1'b1, 2'b10, 1'b1, 1'b0, 32'h2000, 2'b10));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0,    2'b00));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0,    2'b00));
    // pointer wrapped: both request, master 0 wins and keeps the bus (lock, 5 acks)
    vecs.push_back(mk(1'b1, 2'b11, 1'b0, 2'b01, 1'b1, 1'b0, 32'h1000, 2'b00));
    vecs.push_back(mk(1'b1, 2'b11, 1'b1, 2'b01, 1'b1, 1'b0, 32'h1000, 2'b01));
    vecs.push_back(mk(1'b1, 2'b11, 1'b0, 2'b01, 1'b1, 1'b0, 32'h1000, 2'b00));
    vecs.push_back(mk(1'b1, 2'b11, 1'b1, 2'b01, 1'b1, 1'b0, 32'h1000, 2'b01));
    vecs.push_back(mk(1'b1, 2'b11, 1'b0, 2'b01, 1'b1, 1'b0, 32'h1000, 2'b00));
    vecs.push_back(mk(1'b1, 2'b11, 1'b1, 2'b01, 1'b1, 1'b0, 32'h1000, 2'b01));
    vecs.push_back(mk(1'b1, 2'b11, 1'b1, 2'b01, 1'b1, 1'b0, 32'h1000, 2'b01));
    vecs.push_back(mk(1'b1, 2'b11, 1'b1, 2'b01, 1'b1, 1'b0, 32'h1000, 2'b01));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0,    2'b00));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0,    2'b00));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 2'b10, 1'b1, 1'b0, 32'h2000, 2'b00));
    // reset while master 1 owns: grant drops at the edge, none while held
    vecs.push_back(mk(1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0,    2'b00));
    vecs.push_back(mk(1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0,    2'b00));
    // pointer back at 0: master 0 wins
    vecs.push_back(mk(1'b1, 2'b11, 1'b0, 2'b01, 1'b1, 1'b0, 32'h1000, 2'b00));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0,    2'b00));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0,    2'b00));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      bif.i_S_RDATA = 32'h5A00_0000 + 32'(i);
      cyc(vecs[i].rstn, vecs[i].req, vecs[i].ack);
      expect_gt(tag, vecs[i].gnt, vecs[i].tmo);
      chk({tag, ".busy"},  {31'h0, busy}, {31'h0, vecs[i].busy});
      chk({tag, ".m_ack"}, {30'h0, bif.o_M_ACK}, {30'h0, vecs[i].mack});
      chk({tag, ".rdata"}, bif.o_M_RDATA, 32'h5A00_0000 + 32'(i));
      chk_slave(tag, vecs[i].saddr);
    end

    // ---- Watchdog: master 0 holds with no ack, master 1 pending ----
    cyc(1'b0, 2'b00, 1'b0);
    cyc(1'b1, 2'b01, 1'b0);
    expect_gt("to_grant", 2'b01, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 2'b11, 1'b0);
      expect_gt($sformatf("to_hold%0d", i), 2'b01, 1'b0);
    end
    cyc(1'b1, 2'b11, 1'b0);
    expect_gt("to_fire", 2'b00, 1'b1);
    chk("to_fire.busy", {31'h0, busy}, 32'h0);
    chk_slave("to_fire", 32'h0);
    cyc(1'b1, 2'b11, 1'b0);
    expect_gt("to_turn", 2'b00, 1'b0);
    cyc(1'b1, 2'b11, 1'b0);
    expect_gt("to_m1", 2'b10, 1'b0);
    cyc(1'b1, 2'b01, 1'b0);
    expect_gt("to_m1rel", 2'b00, 1'b0);
    cyc(1'b1, 2'b01, 1'b0);
    expect_gt("to_idle", 2'b00, 1'b0);
    cyc(1'b1, 2'b01, 1'b0);
    expect_gt("to_masked", 2'b00, 1'b0);
    cyc(1'b1, 2'b00, 1'b0);
    expect_gt("to_unmask", 2'b00, 1'b0);
    cyc(1'b1, 2'b01, 1'b0);
    expect_gt("to_regrant", 2'b01, 1'b0);
    cyc(1'b1, 2'b00, 1'b0);
    cyc(1'b1, 2'b00, 1'b0);

    // ---- Acks every third cycle keep the watchdog quiet ----
    begin
      int  budget;
      logic a;
      budget = 0;
      cyc(1'b1, 2'b01, 1'b0);
      while (bif.o_GNT !== 2'b01 && budget < 8) begin
        cyc(1'b1, 2'b01, 1'b0);
        budget++;
      end
      chk("ack_wait_grant", {30'h0, bif.o_GNT}, 32'h1);
      for (int i = 0; i < 20; i++) begin
        a = (i % 3 == 2);
        bif.i_S_RDATA = $urandom;
        cyc(1'b1, 2'b11, a);
        expect_gt($sformatf("ack%0d", i), 2'b01, 1'b0);
        chk($sformatf("ack%0d.m_ack", i), {30'h0, bif.o_M_ACK}, a ? 32'h1 : 32'h0);
      end
      cyc(1'b1, 2'b10, 1'b0);
      expect_gt("ack_rel", 2'b00, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
